// File: rtl/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//
// Boots a CPU under test from a program image kept in an internal ROM.
// The ROM is preloaded word by word while idle. A start pulse streams the
// first prog_len words into CPU memory over a req/ack write handshake. The
// CPU is then held in reset for HOLD_CYCLES more cycles and released.
//
// Ports
//   tb_clk       in   test-bench clock; all state changes on its rising edge
//   reset        in   asynchronous active-high reset
//   rom_wr_en    in   ROM preload strobe (accepted only while idle)
//   rom_wr_addr  in   ROM preload index
//   rom_wr_data  in   ROM preload word
//   start        in   begin a load (accepted only while idle)
//   prog_len     in   number of words to load, clamped to ROM_DEPTH
//   mem_req      out  write request to CPU memory
//   mem_addr     out  write address (registered)
//   mem_data     out  write data (registered)
//   mem_ack      in   CPU memory accepted the presented word
//   cpu_reset    out  active-high reset to the CPU core
//   load_done    out  high once the CPU has been released
//   word_count   out  words accepted so far in this load
// -----------------------------------------------------------------------------
module tb_prog_loader #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    ROM_DEPTH   = 256,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR  = '0,
  parameter int                    HOLD_CYCLES = 4
) (
  input  logic                         tb_clk,
  input  logic                         reset,
  input  logic                         rom_wr_en,
  input  logic [$clog2(ROM_DEPTH)-1:0] rom_wr_addr,
  input  logic [DATA_WIDTH-1:0]        rom_wr_data,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        prog_len,
  output logic                         mem_req,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_data,
  input  logic                         mem_ack,
  output logic                         cpu_reset,
  output logic                         load_done,
  output logic [ADDR_WIDTH-1:0]        word_count
);

  localparam int IDX_W  = $clog2(ROM_DEPTH);
  // One extra bit so the clamp value ROM_DEPTH is representable even when
  // it equals 2**ADDR_WIDTH.
  localparam int LEN_W  = ADDR_WIDTH + 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [LEN_W-1:0]  DEPTH_LEN = LEN_W'(ROM_DEPTH);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } state_t;

  // Program image. Deliberately not cleared by reset so a test can reset
  // the loader and boot the same image again.
  logic [DATA_WIDTH-1:0] rom [ROM_DEPTH];

  state_t                state_reg, state_next;
  logic [LEN_W-1:0]      len_reg,   len_next;
  logic [IDX_W-1:0]      idx_reg,   idx_next;
  logic                  req_reg,   req_next;
  logic [ADDR_WIDTH-1:0] addr_reg,  addr_next;
  logic [DATA_WIDTH-1:0] data_reg,  data_next;
  logic [ADDR_WIDTH-1:0] count_reg, count_next;
  logic [HOLD_W-1:0]     hold_reg,  hold_next;

  logic                  rom_we;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rom_rd;
  logic [IDX_W-1:0]      idx_inc;
  logic [LEN_W-1:0]      len_clamped;
  logic [LEN_W-1:0]      count_inc;

  assign idx_inc   = idx_reg + 1'b1;
  assign count_inc = {1'b0, count_reg} + 1'b1;

  assign len_clamped = ({1'b0, prog_len} > DEPTH_LEN) ? DEPTH_LEN : {1'b0, prog_len};

  // The word register mem_data is the registered read port of the ROM.
  // The read index points at the word that will be presented after the
  // next edge: word 0 when starting, the following word while loading.
  assign rd_idx = (state_reg == IDLE) ? '0 : idx_inc;
  assign rom_rd = rom[rd_idx];

  // ROM write port. rom_we is only raised while idle, which is what drops
  // writes attempted in any other state.
  always_ff @(posedge tb_clk) begin
    if (rom_we) begin
      rom[rom_wr_addr] <= rom_wr_data;
    end
  end

  // State and datapath registers.
  always_ff @(posedge tb_clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      len_reg   <= '0;
      idx_reg   <= '0;
      req_reg   <= 1'b0;
      addr_reg  <= START_ADDR;
      data_reg  <= '0;
      count_reg <= '0;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      idx_reg   <= idx_next;
      req_reg   <= req_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      count_reg <= count_next;
      hold_reg  <= hold_next;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    idx_next   = idx_reg;
    req_next   = req_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    count_next = count_reg;
    hold_next  = hold_reg;
    rom_we     = 1'b0;

    case (state_reg)
      IDLE: begin
        rom_we = rom_wr_en;
        if (start) begin
          len_next   = len_clamped;
          idx_next   = '0;
          count_next = '0;
          hold_next  = '0;
          if (len_clamped == '0) begin
            state_next = HOLD;
          end else begin
            state_next = LOAD;
            req_next   = 1'b1;
            addr_next  = START_ADDR;
            // A preload of word 0 in the same cycle lands in the ROM on
            // this edge, so forward it instead of the stale ROM contents.
            if (rom_wr_en && (rom_wr_addr == '0)) begin
              data_next = rom_wr_data;
            end else begin
              data_next = rom_rd;
            end
          end
        end
      end

      LOAD: begin
        // mem_req is always high here, so an ack is always meaningful.
        if (mem_ack) begin
          count_next = count_inc[ADDR_WIDTH-1:0];
          if (count_inc == len_reg) begin
            req_next   = 1'b0;
            hold_next  = '0;
            state_next = HOLD;
          end else begin
            idx_next  = idx_inc;
            // Address wraps silently at the top of the memory space.
            addr_next = START_ADDR + ADDR_WIDTH'(idx_inc);
            data_next = rom_rd;
          end
        end
      end

      HOLD: begin
        hold_next = hold_reg + 1'b1;
        if (hold_reg == HOLD_LAST) begin
          state_next = RUN;
        end
      end

      RUN: begin
        // Terminal until reset; start and preload writes are ignored.
        req_next = 1'b0;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign mem_req    = req_reg;
  assign mem_addr   = addr_reg;
  assign mem_data   = data_reg;
  assign word_count = count_reg;
  // Decoded straight from the state register so the CPU cannot leave reset
  // in any state other than RUN.
  assign cpu_reset  = (state_reg != RUN);
  assign load_done  = (state_reg == RUN);

endmodule

// File: tb/tb_tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_tb_prog_loader
//
// Self-checking bench for tb_prog_loader. Two loaders share all inputs: one
// with START_ADDR = 0 and one with START_ADDR = 16'hFFFE (address wrap).
// A cycle-by-cycle vector table covers the basic 4-word load; hand-written
// sequences cover the throttled ack, zero length, mid-load reset, ignored
// inputs in RUN, write/start forwarding and length clamping.
// -----------------------------------------------------------------------------
module tb_tb_prog_loader;

  logic        tb_clk = 1'b0;
  logic        reset;
  logic        rom_wr_en;
  logic [7:0]  rom_wr_addr;
  logic [15:0] rom_wr_data;
  logic        start;
  logic [15:0] prog_len;
  logic        mem_ack;

  logic        a_mem_req,   b_mem_req;
  logic [15:0] a_mem_addr,  b_mem_addr;
  logic [15:0] a_mem_data,  b_mem_data;
  logic        a_cpu_reset, b_cpu_reset;
  logic        a_load_done, b_load_done;
  logic [15:0] a_word_count, b_word_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 tb_clk = ~tb_clk;

  tb_prog_loader #(.START_ADDR(16'h0000)) dut_a (
    .tb_clk(tb_clk), .reset(reset),
    .rom_wr_en(rom_wr_en), .rom_wr_addr(rom_wr_addr), .rom_wr_data(rom_wr_data),
    .start(start), .prog_len(prog_len),
    .mem_req(a_mem_req), .mem_addr(a_mem_addr), .mem_data(a_mem_data),
    .mem_ack(mem_ack),
    .cpu_reset(a_cpu_reset), .load_done(a_load_done), .word_count(a_word_count)
  );

  tb_prog_loader #(.START_ADDR(16'hFFFE)) dut_b (
    .tb_clk(tb_clk), .reset(reset),
    .rom_wr_en(rom_wr_en), .rom_wr_addr(rom_wr_addr), .rom_wr_data(rom_wr_data),
    .start(start), .prog_len(prog_len),
    .mem_req(b_mem_req), .mem_addr(b_mem_addr), .mem_data(b_mem_data),
    .mem_ack(mem_ack),
    .cpu_reset(b_cpu_reset), .load_done(b_load_done), .word_count(b_word_count)
  );

  typedef struct {
    logic        start;
    logic [15:0] len;
    logic        ack;
    logic        req;
    logic        bus_chk;   // compare address/data only while a word is presented
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] b_addr;
    logic        cpu_rst;
    logic        done;
    logic [15:0] wc;
  } vec_t;

  vec_t vt [0:9];
  logic [15:0] img [0:7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0; rom_wr_en = 1'b0; mem_ack = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    rom_wr_en = 1'b1; rom_wr_addr = a; rom_wr_data = d;
    tick();
    rom_wr_en = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    for (int k = 0; k < budget && !a_load_done; k++) tick();
    check(nm, a_load_done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nwr;
    logic waiting;
    logic [15:0] pa, pd;

    img[0] = 16'h1111; img[1] = 16'h2222; img[2] = 16'h3333; img[3] = 16'h4444;
    img[4] = 16'h5555; img[5] = 16'h6666; img[6] = 16'h7777; img[7] = 16'h8888;

    //            start len ack | req chk addr     data     b_addr   cpu done wc
    vt[0] = '{1'b1, 16'd4, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h1111, 16'hFFFE, 1'b1, 1'b0, 16'd0};
    vt[1] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 16'h0001, 16'h2222, 16'hFFFF, 1'b1, 1'b0, 16'd1};
    vt[2] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 16'h0002, 16'h3333, 16'h0000, 1'b1, 1'b0, 16'd2};
    vt[3] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 16'h0003, 16'h4444, 16'h0001, 1'b1, 1'b0, 16'd3};
    vt[4] = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'd4};
    vt[5] = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'd4};
    vt[6] = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'd4};
    vt[7] = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'd4};
    vt[8] = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'd4};
    vt[9] = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'd4};

    reset = 1'b1; rom_wr_en = 1'b0; rom_wr_addr = '0; rom_wr_data = '0;
    start = 1'b0; prog_len = '0; mem_ack = 1'b0;
    tick();

    // Reset values
    check("rst mem_req",    a_mem_req,    0);
    check("rst mem_addr",   a_mem_addr,   16'h0000);
    check("rst b_mem_addr", b_mem_addr,   16'hFFFE);
    check("rst mem_data",   a_mem_data,   0);
    check("rst cpu_reset",  a_cpu_reset,  1);
    check("rst load_done",  a_load_done,  0);
    check("rst word_count", a_word_count, 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) preload(8'(i), img[i]);

    // Test 1 / 4: table-driven 4-word load, ack tied high
    for (int i = 0; i < 10; i++) begin
      start = vt[i].start; prog_len = vt[i].len; mem_ack = vt[i].ack;
      tick();
      $display("t1 vec %0d: req=%0b addr=%h data=%h b_addr=%h cpu_reset=%0b done=%0b wc=%0d",
               i, a_mem_req, a_mem_addr, a_mem_data, b_mem_addr, a_cpu_reset, a_load_done, a_word_count);
      check($sformatf("t1[%0d] mem_req", i),    a_mem_req,    vt[i].req);
      check($sformatf("t1[%0d] cpu_reset", i),  a_cpu_reset,  vt[i].cpu_rst);
      check($sformatf("t1[%0d] load_done", i),  a_load_done,  vt[i].done);
      check($sformatf("t1[%0d] word_count", i), a_word_count, vt[i].wc);
      if (vt[i].bus_chk) begin
        check($sformatf("t1[%0d] mem_addr", i),   a_mem_addr, vt[i].addr);
        check($sformatf("t1[%0d] mem_data", i),   a_mem_data, vt[i].data);
        check($sformatf("t1[%0d] b_mem_addr", i), b_mem_addr, vt[i].b_addr);
        check($sformatf("t1[%0d] b_mem_data", i), b_mem_data, vt[i].data);
      end
    end
    start = 1'b0;

    // Test 2: ack only every third cycle
    do_reset();
    start = 1'b1; prog_len = 16'd4;
    tick();
    start = 1'b0;
    nwr = 0; waiting = 1'b0; pa = '0; pd = '0;
    for (int c = 0; c < 40 && nwr < 4; c++) begin
      mem_ack = ((c % 3) == 2);
      if (waiting) begin
        check("t2 req held",  a_mem_req,  1);
        check("t2 addr held", a_mem_addr, pa);
        check("t2 data held", a_mem_data, pd);
      end
      if (a_mem_req && mem_ack) begin
        $display("t2 write %0d: addr=%h data=%h", nwr, a_mem_addr, a_mem_data);
        check($sformatf("t2 write %0d addr", nwr), a_mem_addr, 16'(nwr));
        check($sformatf("t2 write %0d data", nwr), a_mem_data, img[nwr]);
        nwr++;
        waiting = 1'b0;
      end else if (a_mem_req) begin
        waiting = 1'b1; pa = a_mem_addr; pd = a_mem_data;
      end
      tick();
    end
    check("t2 writes seen", nwr, 4);
    mem_ack = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("t2 no extra req %0d", k), a_mem_req, 0);
      tick();
    end
    check("t2 word_count", a_word_count, 4);
    check("t2 load_done",  a_load_done,  1);
    check("t2 cpu_reset",  a_cpu_reset,  0);

    // Test 3: zero-length load
    do_reset();
    start = 1'b1; prog_len = 16'd0; mem_ack = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t3 req %0d", k),       a_mem_req,   0);
      check($sformatf("t3 cpu_reset %0d", k), a_cpu_reset, 1);
      tick();
    end
    $display("t3 end: req=%0b cpu_reset=%0b done=%0b wc=%0d", a_mem_req, a_cpu_reset, a_load_done, a_word_count);
    check("t3 cpu_reset released", a_cpu_reset,  0);
    check("t3 load_done",          a_load_done,  1);
    check("t3 word_count",         a_word_count, 0);
    check("t3 req",                a_mem_req,    0);

    // Test 5: asynchronous reset after the second ack of an 8-word load
    do_reset();
    start = 1'b1; prog_len = 16'd8; mem_ack = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("t5 wc before reset", a_word_count, 2);
    reset = 1'b1;
    #2;
    check("t5 async req",       a_mem_req,    0);
    check("t5 async cpu_reset", a_cpu_reset,  1);
    check("t5 async wc",        a_word_count, 0);
    check("t5 async addr",      a_mem_addr,   16'h0000);
    @(posedge tb_clk); #1;
    reset = 1'b0; mem_ack = 1'b0;
    start = 1'b1; prog_len = 16'd8;
    tick();
    start = 1'b0;
    $display("t5 restart: req=%0b addr=%h data=%h wc=%0d", a_mem_req, a_mem_addr, a_mem_data, a_word_count);
    check("t5 restart req",  a_mem_req,    1);
    check("t5 restart addr", a_mem_addr,   16'h0000);
    check("t5 restart data", a_mem_data,   16'h1111);
    check("t5 restart wc",   a_word_count, 0);
    mem_ack = 1'b1;
    wait_done(30, "t5 load_done");
    check("t5 word_count", a_word_count, 8);

    // Test 6: start and ROM write ignored in RUN
    start = 1'b1; prog_len = 16'd2;
    rom_wr_en = 1'b1; rom_wr_addr = 8'd0; rom_wr_data = 16'hDEAD;
    tick();
    start = 1'b0; rom_wr_en = 1'b0;
    check("t6 req",       a_mem_req,    0);
    check("t6 load_done", a_load_done,  1);
    check("t6 cpu_reset", a_cpu_reset,  0);
    check("t6 wc",        a_word_count, 8);
    tick();
    check("t6 req later", a_mem_req, 0);
    do_reset();
    start = 1'b1; prog_len = 16'd1;
    tick();
    start = 1'b0;
    $display("t6 reload: addr=%h data=%h", a_mem_addr, a_mem_data);
    check("t6 rom unchanged", a_mem_data, 16'h1111);

    // Write to word 0 together with start: the new word is presented
    do_reset();
    rom_wr_en = 1'b1; rom_wr_addr = 8'd0; rom_wr_data = 16'h5A5A;
    start = 1'b1; prog_len = 16'd1;
    tick();
    rom_wr_en = 1'b0; start = 1'b0;
    $display("fwd: req=%0b data=%h", a_mem_req, a_mem_data);
    check("fwd req",  a_mem_req,  1);
    check("fwd data", a_mem_data, 16'h5A5A);

    // Length clamped to ROM_DEPTH
    do_reset();
    start = 1'b1; prog_len = 16'd300; mem_ack = 1'b1;
    tick();
    start = 1'b0;
    wait_done(300, "clamp load_done");
    $display("clamp: wc=%0d", a_word_count);
    check("clamp word_count", a_word_count, 256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
